frame_blitter: RTL and testbench

//  Copies one of NUM_IMG ROM-resident images, pixel by pixel, into the VGA adapter's frame buffer.

---
 rtl/vga_blit_pkg.sv | 18 +
 rtl/blit_delay_line.sv | 42 ++++
 rtl/frame_blitter.sv | 159 +++++++++++++++
 tb/tb_frame_blitter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_blit_pkg.sv
// Shared definitions for the VGA image blitter: FSM state codes, a width
// helper that never returns zero, and the default screen geometry.
package vga_blit_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bits needed to index n items; a single item still gets a 1-bit field.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register that carries per-pixel side information
// alongside the ROM read, so it emerges in step with rom_q.
module blit_delay_line
    import vga_blit_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    output logic         busy
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Advance every stage by one per cycle; reset empties the whole line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            // NOTE: the payload array is cleared as well; it is only a few
            // registers deep, and a flushed line must never leak stale coords.
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_in;
            data_q[0]  <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_out = valid_q[DEPTH-1];
    assign data_out  = data_q[DEPTH-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/frame_blitter.sv
// Copies one of NUM_IMG ROM images into the VGA frame buffer at a run-time
// origin, clipping pixels that fall off the screen.
// Optional feature: define FRAME_BLITTER_TRANSP_EN to suppress plotting of
// pixels whose colour equals KEY_COLOUR (frame timing is unaffected).
module frame_blitter
    import vga_blit_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int COLOUR_W   = 3,
    parameter int NUM_IMG    = 4,
    parameter int ROM_LAT    = 1,
    parameter int KEY_COLOUR = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [clog2w(NUM_IMG)-1:0]          img_sel,
    input  logic [clog2w(SCREEN_W)-1:0]         x0,
    input  logic [clog2w(SCREEN_H)-1:0]         y0,
    output logic [clog2w(NUM_IMG)-1:0]          rom_sel,
    output logic [clog2w(IMG_W*IMG_H)-1:0]      rom_addr,
    input  logic [COLOUR_W-1:0]                 rom_q,
    output logic [clog2w(SCREEN_W)-1:0]         x_counter,
    output logic [clog2w(SCREEN_H)-1:0]         y_counter,
    output logic [COLOUR_W-1:0]                 colour,
    output logic                                plot,
    output logic                                done
);

    localparam int N    = IMG_W * IMG_H;
    localparam int A_W  = clog2w(N);
    localparam int SW_W = clog2w(SCREEN_W);
    localparam int SH_W = clog2w(SCREEN_H);
    localparam int IX_W = clog2w(IMG_W);
    localparam int IY_W = clog2w(IMG_H);
    localparam int SX_W = SW_W + 1;
    localparam int SY_W = SH_W + 1;
    localparam int DL_W = 1 + SW_W + SH_W;

    localparam logic [COLOUR_W-1:0] KEY = COLOUR_W'(KEY_COLOUR);
`ifdef FRAME_BLITTER_TRANSP_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic [1:0]      state;
    logic [SW_W-1:0] x0_q;
    logic [SH_W-1:0] y0_q;
    logic [IX_W-1:0] ix;
    logic [IY_W-1:0] iy;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;
    logic            in_bounds;
    logic            accept;
    logic            last_addr;
    logic            pix_on;

    logic            line_busy;
    logic            tap_valid;
    logic [DL_W-1:0] tap_data;
    logic            tap_in;
    logic [SW_W-1:0] tap_sx;
    logic [SH_W-1:0] tap_sy;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_addr = (rom_addr == A_W'(N - 1));

    // Screen position is one bit wider so an overflow past the edge is caught.
    assign sx        = SX_W'(x0_q) + SX_W'(ix);
    assign sy        = SY_W'(y0_q) + SY_W'(iy);
    assign in_bounds = (sx < SX_W'(SCREEN_W)) && (sy < SY_W'(SCREEN_H));

    // Frame sequencing plus the row-major address and (ix,iy) walkers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rom_sel  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            rom_addr <= '0;
            ix       <= '0;
            iy       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state    <= ST_FETCH;
                        rom_sel  <= img_sel;
                        x0_q     <= x0;
                        y0_q     <= y0;
                        rom_addr <= '0;
                        ix       <= '0;
                        iy       <= '0;
                    end
                end
                ST_FETCH: begin
                    if (last_addr) begin
                        state <= ST_DRAIN;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        if (ix == IX_W'(IMG_W - 1)) begin
                            ix <= '0;
                            iy <= iy + 1'b1;
                        end else begin
                            ix <= ix + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!line_busy) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Side information rides ROM_LAT cycles to meet its pixel's rom_q.
    blit_delay_line #(
        .DEPTH (ROM_LAT),
        .W     (DL_W)
    ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (state == ST_FETCH),
        .data_in   ({in_bounds, sx[SW_W-1:0], sy[SH_W-1:0]}),
        .valid_out (tap_valid),
        .data_out  (tap_data),
        .busy      (line_busy)
    );

    assign {tap_in, tap_sx, tap_sy} = tap_data;
    assign pix_on = tap_valid && tap_in && !(TRANSP && (rom_q == KEY));

    // VGA-side registers: plot every slot, coordinates/colour only on a write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            plot      <= 1'b0;
            x_counter <= '0;
            y_counter <= '0;
            colour    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            plot <= pix_on;
            if (pix_on) begin
                x_counter <= tap_sx;
                y_counter <= tap_sy;
                colour    <= rom_q;
            end
        end
    end

    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_frame_blitter.sv
// Self-checking bench for frame_blitter: a 4x3 image on a 160x120 screen,
// checked cycle by cycle against a pixel-list reference model.
module tb_frame_blitter;

    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int N     = IMG_W * IMG_H;
    localparam int NI    = 4;
    localparam int LAT   = 1;
    localparam int KEY   = 0;
`ifdef FRAME_BLITTER_TRANSP_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] img_sel = '0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [1:0] rom_sel;
    logic [3:0] rom_addr;
    logic [2:0] rom_q = '0;
    logic [7:0] x_counter;
    logic [6:0] y_counter;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int checks = 0;
    int errors = 0;
    int exp_x  = 0;
    int exp_y  = 0;
    int exp_c  = 0;
    logic [2:0] rom [NI*N];

    frame_blitter #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .COLOUR_W   (3),
        .NUM_IMG    (NI),
        .ROM_LAT    (LAT),
        .KEY_COLOUR (KEY)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .start     (start),
        .img_sel   (img_sel),
        .x0        (x0),
        .y0        (y0),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .x_counter (x_counter),
        .y_counter (y_counter),
        .colour    (colour),
        .plot      (plot),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Single-cycle synchronous ROM shared by all images.
    always @(posedge clock)
        rom_q <= rom[(int'(rom_sel) * N + int'(rom_addr)) % (NI * N)];

    // Run one frame from an accepted start; every cycle is compared with the model.
    task automatic run_frame(input int sel, input int fx, input int fy,
                             input int inject_c, input string name);
        int plots, exp_plots, k, sx, sy;
        bit e_plot, e_done;
        plots = 0;
        exp_plots = 0;
        @(negedge clock);
        start = 1'b1;
        img_sel = 2'(sel);
        x0 = 8'(fx);
        y0 = 7'(fy);
        for (int c = 0; c <= N + LAT + 3; c++) begin
            @(posedge clock);
            #1;
            k = c - (LAT + 1);
            e_plot = 1'b0;
            if (k >= 0 && k < N) begin
                sx = fx + (k % IMG_W);
                sy = fy + (k / IMG_W);
                if (sx < SW && sy < SH && !(TRANSP && int'(rom[sel*N+k]) == KEY)) begin
                    e_plot = 1'b1;
                    exp_x = sx;
                    exp_y = sy;
                    exp_c = int'(rom[sel*N+k]);
                    exp_plots++;
                end
            end
            e_done = (c >= N + LAT + 1);
            checks++;
            if (plot !== e_plot) begin
                errors++;
                $display("FAIL %s plot c=%0d: got %b expected %b", name, c, plot, e_plot);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL %s done c=%0d: got %b expected %b", name, c, done, e_done);
            end
            checks++;
            if (x_counter !== 8'(exp_x) || y_counter !== 7'(exp_y) || colour !== 3'(exp_c)) begin
                errors++;
                $display("FAIL %s pixel c=%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         name, c, x_counter, y_counter, colour, exp_x, exp_y, exp_c);
            end
            checks++;
            if (rom_sel !== 2'(sel)) begin
                errors++;
                $display("FAIL %s rom_sel c=%0d: got %0d expected %0d", name, c, rom_sel, sel);
            end
            if (c < N) begin
                checks++;
                if (rom_addr !== 4'(c)) begin
                    errors++;
                    $display("FAIL %s rom_addr c=%0d: got %0d expected %0d", name, c, rom_addr, c);
                end
            end
            if (plot === 1'b1) plots++;
            if (c == 0) begin
                start = 1'b0;
                img_sel = 2'($urandom);
                x0 = 8'($urandom);
                y0 = 7'($urandom);
            end
            if (c == inject_c) begin
                start = 1'b1;
                img_sel = 2'($urandom);
                x0 = 8'($urandom);
                y0 = 7'($urandom);
            end else if (c == inject_c + 1) begin
                start = 1'b0;
            end
        end
        checks++;
        if (plots !== exp_plots) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d expected %0d", name, plots, exp_plots);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || x_counter !== '0 || y_counter !== '0 ||
            colour !== '0 || rom_addr !== '0 || rom_sel !== '0) begin
            errors++;
            $display("FAIL reset_state: got plot=%b done=%b x=%0d y=%0d c=%0d a=%0d s=%0d expected all 0",
                     plot, done, x_counter, y_counter, colour, rom_addr, rom_sel);
        end
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got plot=%b done=%b expected 0 0", plot, done);
        end
        exp_x = 0;
        exp_y = 0;
        exp_c = 0;
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        start = 1'b1;
        img_sel = 2'd1;
        x0 = 8'd10;
        y0 = 7'd20;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || x_counter !== '0 || y_counter !== '0 ||
            colour !== '0 || rom_addr !== '0 || rom_sel !== '0) begin
            errors++;
            $display("FAIL async_reset: got plot=%b done=%b x=%0d y=%0d c=%0d a=%0d s=%0d expected all 0",
                     plot, done, x_counter, y_counter, colour, rom_addr, rom_sel);
        end
        exp_x = 0;
        exp_y = 0;
        exp_c = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if (plot !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet c=%0d: got plot=%b done=%b expected 0 0", c, plot, done);
            end
        end
        run_frame(1, 10, 20, -1, "after_reset");
    endtask

    task automatic test_transparency();
        int p0, p1, p2;
        for (int j = 0; j < N; j++) rom[N+j] = 3'($urandom_range(1, 7));
        p0 = $urandom_range(0, 3);
        p1 = $urandom_range(4, 7);
        p2 = $urandom_range(8, 11);
        rom[N+p0] = 3'd0;
        rom[N+p1] = 3'd0;
        rom[N+p2] = 3'd0;
        run_frame(1, 0, 0, -1, "transparency");
    endtask

    task automatic test_random();
        int fx, fy;
        for (int i = 0; i < 8; i++) begin
            fx = (i % 2 == 0) ? $urandom_range(0, SW - 1) : $urandom_range(SW - 5, SW - 1);
            fy = (i % 3 == 0) ? $urandom_range(0, SH - 1) : $urandom_range(SH - 4, SH - 1);
            run_frame($urandom_range(0, NI - 1), fx, fy, -1, "random");
        end
    endtask

    initial begin
        for (int j = 0; j < NI * N; j++) rom[j] = 3'($urandom);
        #1;
        test_reset();
        run_frame(0, 0, 0, -1, "full_frame");
        run_frame(2, 158, 118, -1, "clipping");
        run_frame(0, 0, 0, 4, "start_mid_frame");
        run_frame(3, 50, 60, N + LAT, "start_at_done_edge");
        run_frame(2, 30, 40, -1, "img_sel_2");
        run_frame(0, 70, 80, -1, "img_sel_0");
        test_transparency();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
